// File: rtl/dma_2d_sequencer.sv
// dma_2d_sequencer: walks a 2-D block transfer row by row. Each row gets a
// read-engine command and then a write-engine command, strictly in that order.
// Source and destination pointers advance by their strides between rows.
// Optional feature: define DMA2D_SEQ_ABORT_EN to add the i_abort input.
module dma_2d_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  input  logic [ADDR_WIDTH-1:0] i_src_stride,
  input  logic [ADDR_WIDTH-1:0] i_dst_stride,
  input  logic [LEN_WIDTH-1:0]  i_row_len,
  input  logic [CNT_WIDTH-1:0]  i_row_cnt,
  input  logic                  i_rd_done,
  input  logic                  i_rd_error,
  input  logic                  i_wr_done,
  input  logic                  i_wr_error,
`ifdef DMA2D_SEQ_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic                  o_rd_init,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [LEN_WIDTH-1:0]  o_rd_len,
  output logic                  o_wr_init,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [LEN_WIDTH-1:0]  o_wr_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [CNT_WIDTH-1:0]  o_row_idx
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_WAIT  = 3'd4,
    S_NEXT_ROW = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH-1:0] r_src_stride;
  logic [ADDR_WIDTH-1:0] r_dst_stride;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_row_cnt;
  logic [CNT_WIDTH-1:0]  r_row_idx;
  logic                  r_rd_init;
  logic                  r_wr_init;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_rd_done_d;
  logic                  r_wr_done_d;
  logic                  r_abort_pend;

  logic                  w_rd_rise;
  logic                  w_wr_rise;
  logic                  w_abort;
  logic                  w_last_row;

`ifdef DMA2D_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Only a fresh 0->1 transition of the engine done level counts as completion.
  assign w_rd_rise  = i_rd_done & ~r_rd_done_d;
  assign w_wr_rise  = i_wr_done & ~r_wr_done_d;
  assign w_last_row = (r_row_idx == (r_row_cnt - CNT_WIDTH'(1)));

  // Main sequencer: state, latched config, row pointers and all registered outputs.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_len        <= '0;
      r_row_cnt    <= '0;
      r_row_idx    <= '0;
      r_rd_init    <= 1'b0;
      r_wr_init    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_rd_done_d  <= 1'b0;
      r_wr_done_d  <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_rd_done_d <= i_rd_done;
      r_wr_done_d <= i_wr_done;
      // INIT and DONE are single-cycle pulses unless a branch re-asserts them.
      r_rd_init   <= 1'b0;
      r_wr_init   <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src        <= i_src_base;
            r_dst        <= i_dst_base;
            r_src_stride <= i_src_stride;
            r_dst_stride <= i_dst_stride;
            r_len        <= i_row_len;
            r_row_cnt    <= i_row_cnt;
            r_row_idx    <= '0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
            if ((i_row_cnt == '0) || (i_row_len == '0)) begin
              // Empty transfer: complete without touching either engine.
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_RD_ISSUE;
              r_rd_init <= 1'b1;
              r_busy    <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_ISSUE: begin
          if (w_abort) begin
            r_error <= 1'b1;
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (w_rd_rise) begin
            if (i_rd_error || w_abort || r_abort_pend) begin
              r_error      <= 1'b1;
              r_abort_pend <= 1'b0;
              r_state      <= S_FINISH;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state   <= S_WR_ISSUE;
              r_wr_init <= 1'b1;
            end
          end else begin
            // An abort here must still let the outstanding read complete.
            r_abort_pend <= r_abort_pend | w_abort;
          end
        end
        S_WR_ISSUE: begin
          if (w_abort) begin
            r_error <= 1'b1;
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (w_wr_rise) begin
            if (i_wr_error || w_abort || r_abort_pend) begin
              r_error      <= 1'b1;
              r_abort_pend <= 1'b0;
              r_state      <= S_FINISH;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state <= S_NEXT_ROW;
            end
          end else begin
            r_abort_pend <= r_abort_pend | w_abort;
          end
        end
        S_NEXT_ROW: begin
          if (w_abort) begin
            r_error <= 1'b1;
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            // Pointers wrap silently at the address width.
            r_src     <= r_src + r_src_stride;
            r_dst     <= r_dst + r_dst_stride;
            r_row_idx <= r_row_idx + CNT_WIDTH'(1);
            if (w_last_row) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_RD_ISSUE;
              r_rd_init <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_init = r_rd_init;
  assign o_rd_addr = r_src;
  assign o_rd_len  = r_len;
  assign o_wr_init = r_wr_init;
  assign o_wr_addr = r_dst;
  assign o_wr_len  = r_len;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_row_idx = r_row_idx;

endmodule

// File: tb/tb_dma_2d_sequencer.sv
// tb_dma_2d_sequencer: directed scenarios for dma_2d_sequencer. Two simple
// engine responders answer each INIT after a fixed latency. A closed-form
// timeline model derives every output per cycle from the transfer parameters.
module tb_dma_2d_sequencer;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start;
  logic [AW-1:0] src_base, dst_base, src_stride, dst_stride;
  logic [LW-1:0] row_len;
  logic [CW-1:0] row_cnt;
  logic          rd_eng, rd_man, wr_eng, wr_err_eng;
  logic          rd_done, wr_done, rd_error, wr_error;
`ifdef DMA2D_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          o_rd_init, o_wr_init, o_busy, o_done, o_error;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [LW-1:0] o_rd_len, o_wr_len;
  logic [CW-1:0] o_row_idx;

  assign rd_done  = rd_eng | rd_man;
  assign rd_error = 1'b0;
  assign wr_done  = wr_eng;
  assign wr_error = wr_err_eng;

  always #5 clk = ~clk;

  dma_2d_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .i_aclk(clk), .i_aresetn(aresetn), .i_start(start),
    .i_src_base(src_base), .i_dst_base(dst_base),
    .i_src_stride(src_stride), .i_dst_stride(dst_stride),
    .i_row_len(row_len), .i_row_cnt(row_cnt),
    .i_rd_done(rd_done), .i_rd_error(rd_error),
    .i_wr_done(wr_done), .i_wr_error(wr_error),
`ifdef DMA2D_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_rd_init(o_rd_init), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .o_wr_init(o_wr_init), .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_row_idx(o_row_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus knobs shared by the engines and the model.
  bit eng_en  = 1'b0;
  int lat     = 5;
  int err_row = -1;

  // Read engine: one-cycle done pulse lat cycles after each RD_INIT.
  initial begin
    rd_eng = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_en && o_rd_init === 1'b1) begin
        repeat (lat) @(negedge clk);
        rd_eng = 1'b1;
        @(negedge clk);
        rd_eng = 1'b0;
      end
    end
  end

  // Write engine: same, optionally flagging an error on one row.
  initial begin
    wr_eng = 1'b0;
    wr_err_eng = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_en && o_wr_init === 1'b1) begin
        repeat (lat) @(negedge clk);
        wr_eng     = 1'b1;
        wr_err_eng = (err_row >= 0) && (int'(o_row_idx) == err_row);
        @(negedge clk);
        wr_eng     = 1'b0;
        wr_err_eng = 1'b0;
      end
    end
  end

  // Event monitor: counts pulses and logs command addresses.
  int cnt_done = 0, cnt_busy = 0, cnt_rd = 0, cnt_wr = 0, last_done_cyc = 0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int ev_log[$];
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      cnt_done <= cnt_done + 1;
      last_done_cyc <= cyc;
    end
    if (o_busy === 1'b1) cnt_busy <= cnt_busy + 1;
    if (o_rd_init === 1'b1) begin
      cnt_rd <= cnt_rd + 1;
      rd_log.push_back(o_rd_addr);
      ev_log.push_back(0);
    end
    if (o_wr_init === 1'b1) begin
      cnt_wr <= cnt_wr + 1;
      wr_log.push_back(o_wr_addr);
      ev_log.push_back(1);
    end
  end

  // Timeline model parameters for the transfer in flight.
  bit            m_on = 1'b0;
  int            m_t0 = 0;
  logic [AW-1:0] m_src, m_dst, m_ss, m_ds;
  int            m_len, m_cnt, m_err;

  // Compare process: every cycle after START, derive all outputs from the
  // row timeline (period 2*lat+3 per row) and check the DUT against it.
  always @(negedge clk) begin : cmp
    int d, f, p, dd, k, ninit, nnext;
    bit e_rd, e_wr, e_err;
    logic [AW-1:0] e_src, e_dst;
    if (m_on && aresetn === 1'b1 && (cyc - m_t0) >= 1) begin
      d = cyc - m_t0;
      p = 2 * lat + 3;
      e_err = 1'b0;
      if (m_cnt == 0 || m_len == 0) begin
        f = 1; ninit = 0; nnext = 0;
      end else if (m_err >= 0 && m_err < m_cnt) begin
        f = (m_err + 1) * p; ninit = m_err + 1; nnext = m_err; e_err = 1'b1;
      end else begin
        f = m_cnt * p + 1; ninit = m_cnt; nnext = m_cnt;
      end
      dd = (d > f) ? f : d;
      k = 0;
      for (int n = 0; n < nnext; n++) if ((n + 1) * p < dd) k++;
      e_rd = 1'b0;
      e_wr = 1'b0;
      for (int n = 0; n < ninit; n++) begin
        if (d == 1 + n * p) e_rd = 1'b1;
        if (d == 2 + lat + n * p) e_wr = 1'b1;
      end
      e_src = m_src + AW'(k) * m_ss;
      e_dst = m_dst + AW'(k) * m_ds;
      chk("busy",    o_busy,    (d < f));
      chk("done",    o_done,    (d == f));
      chk("error",   o_error,   e_err && (d >= f));
      chk("rd_init", o_rd_init, e_rd);
      chk("wr_init", o_wr_init, e_wr);
      chk("row_idx", o_row_idx, k);
      chk("rd_addr", o_rd_addr, e_src);
      chk("wr_addr", o_wr_addr, e_dst);
      chk("rd_len",  o_rd_len,  m_len);
      chk("wr_len",  o_wr_len,  m_len);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int ri0, wi0, ei0, d0, b0, r0, w0;

  task automatic snap();
    ri0 = rd_log.size(); wi0 = wr_log.size(); ei0 = ev_log.size();
    d0 = cnt_done; b0 = cnt_busy; r0 = cnt_rd; w0 = cnt_wr;
  endtask

  task automatic wait_done(input string nm);
    int i;
    i = 0;
    while (cnt_done == d0 && i < 2000) begin
      step();
      i++;
    end
    chk(nm, cnt_done - d0, 1);
  endtask

  // Launch one modelled transfer; optionally re-pulse START mid-transfer.
  task automatic run_scn(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                         input logic [AW-1:0] ss, input logic [AW-1:0] ds,
                         input int len, input int cnt, input int erow,
                         input int restart_at, input string nm);
    step();
    src_base = sb; dst_base = db; src_stride = ss; dst_stride = ds;
    row_len = LW'(len); row_cnt = CW'(cnt); err_row = erow;
    m_src = sb; m_dst = db; m_ss = ss; m_ds = ds;
    m_len = len; m_cnt = cnt; m_err = erow; m_t0 = cyc; m_on = 1'b1;
    snap();
    start = 1'b1;
    step();
    start = 1'b0;
    if (restart_at > 0) begin
      repeat (restart_at - 1) step();
      src_base = sb + 32'h40;
      row_cnt  = CW'(cnt + 3);
      start    = 1'b1;
      step();
      start    = 1'b0;
    end
    wait_done(nm);
    repeat (3) step();
  endtask

  int t0;

  initial begin
    aresetn = 1'b0; start = 1'b0; rd_man = 1'b0;
    src_base = '0; dst_base = '0; src_stride = '0; dst_stride = '0;
    row_len = '0; row_cnt = '0;
`ifdef DMA2D_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) step();
    chk("rst_busy", o_busy, 1'b0);       chk("rst_done", o_done, 1'b0);
    chk("rst_error", o_error, 1'b0);     chk("rst_rd_init", o_rd_init, 1'b0);
    chk("rst_wr_init", o_wr_init, 1'b0); chk("rst_row_idx", o_row_idx, 0);
    chk("rst_rd_addr", o_rd_addr, 0);    chk("rst_wr_addr", o_wr_addr, 0);
    chk("rst_rd_len", o_rd_len, 0);      chk("rst_wr_len", o_wr_len, 0);
    aresetn = 1'b1;
    eng_en  = 1'b1;

    // Three rows, 5-cycle engines: period 13, DONE at offset 40.
    run_scn(32'h1000, 32'h8000, 32'h100, 32'h200, 64, 3, -1, 0, "ex1_done");
    chk("ex1_rd0", rd_log[ri0],   32'h1000); chk("ex1_rd1", rd_log[ri0+1], 32'h1100);
    chk("ex1_rd2", rd_log[ri0+2], 32'h1200); chk("ex1_wr0", wr_log[wi0],   32'h8000);
    chk("ex1_wr1", wr_log[wi0+1], 32'h8200); chk("ex1_wr2", wr_log[wi0+2], 32'h8400);
    for (int i = 0; i < 6; i++) chk("ex1_order", ev_log[ei0+i], i % 2);
    chk("ex1_done_cyc", last_done_cyc - m_t0, 40);
    chk("ex1_error", o_error, 1'b0);

    // Zero rows: DONE one cycle after START, no commands, never busy.
    run_scn(32'h3000, 32'h4000, 32'h10, 32'h10, 16, 0, -1, 0, "ex2_done");
    chk("ex2_done_cyc", last_done_cyc - m_t0, 1);
    chk("ex2_rd_cnt", cnt_rd - r0, 0);
    chk("ex2_wr_cnt", cnt_wr - w0, 0);
    chk("ex2_busy_cnt", cnt_busy - b0, 0);

    // Zero length behaves as an empty transfer too.
    run_scn(32'h3000, 32'h4000, 32'h10, 32'h10, 0, 3, -1, 0, "ex2b_done");
    chk("ex2b_rd_cnt", cnt_rd - r0, 0);

    // Write error on row 1 of 4: stop after that row, no row-2 read.
    run_scn(32'h2000, 32'h9000, 32'h40, 32'h80, 32, 4, 1, 0, "ex3_done");
    chk("ex3_error", o_error, 1'b1);
    chk("ex3_rd_cnt", cnt_rd - r0, 2);
    chk("ex3_done_cyc", last_done_cyc - m_t0, 26);

    // Source wrap at 2^32, with an ignored START during BUSY; clears ERROR.
    run_scn(32'hFFFF_FF00, 32'h0, 32'h100, 32'h20, 8, 2, -1, 8, "ex4_done");
    chk("ex4_rd1", rd_log[ri0+1], 32'h0000_0000);
    chk("ex4_error", o_error, 1'b0);
    chk("ex4_rd_cnt", cnt_rd - r0, 2);

    // RD_DONE already high: no progress until a genuine edge; reset in WR_WAIT.
    m_on = 1'b0; eng_en = 1'b0; rd_man = 1'b1;
    repeat (3) step();
    src_base = 32'h5000; dst_base = 32'h6000; row_cnt = CW'(2); row_len = LW'(4);
    snap(); t0 = cyc; start = 1'b1;
    step(); start = 1'b0;
    repeat (12) step();
    chk("stall_busy", o_busy, 1'b1);
    chk("stall_rd_cnt", cnt_rd - r0, 1);
    chk("stall_wr_cnt", cnt_wr - w0, 0);
    rd_man = 1'b0;
    step(); rd_man = 1'b1;
    step();
    chk("stall_wr_init", o_wr_init, 1'b1);
    chk("stall_wr_addr", o_wr_addr, 32'h6000);
    step(); aresetn = 1'b0;
    step();
    chk("wrst_busy", o_busy, 1'b0);       chk("wrst_done", o_done, 1'b0);
    chk("wrst_error", o_error, 1'b0);     chk("wrst_rd_init", o_rd_init, 1'b0);
    chk("wrst_wr_init", o_wr_init, 1'b0); chk("wrst_row_idx", o_row_idx, 0);
    chk("wrst_rd_addr", o_rd_addr, 0);    chk("wrst_wr_addr", o_wr_addr, 0);
    chk("wrst_rd_len", o_rd_len, 0);      chk("wrst_wr_len", o_wr_len, 0);
    aresetn = 1'b1; rd_man = 1'b0;
    repeat (8) step();
    chk("wrst_no_done", cnt_done - d0, 0);
    chk("wrst_idle", o_busy, 1'b0);
    eng_en = 1'b1;

    // Transfer right after reset release completes normally.
    run_scn(32'h100, 32'h200, 32'h4, 32'h8, 2, 2, -1, 0, "post_rst_done");

`ifdef DMA2D_SEQ_ABORT_EN
    // Abort in row-0 RD_WAIT: read completes at offset 6, DONE at offset 7.
    m_on = 1'b0;
    step();
    src_base = 32'h1000; dst_base = 32'h8000; row_cnt = CW'(3); row_len = LW'(64);
    err_row = -1; snap(); t0 = cyc; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); abort = 1'b1;
    step(); abort = 1'b0;
    wait_done("abort_done");
    chk("abort_done_cyc", last_done_cyc - t0, 7);
    chk("abort_wr_cnt", cnt_wr - w0, 0);
    chk("abort_error", o_error, 1'b1);
    repeat (8) step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
